apb_arbiter: RTL and testbench
==============================

# apb_arbiter

Two-requester APB arbiter that shares the single debugger APB completer between the I2C-to-APB adapter and a second bus requester (UART bridge or on-chip test sequencer). It registers each granted transfer, replays it on the completer as a standard SETUP/ACCESS sequence, and returns read data and completion to the winning requester. Arbitration is round-robin per transfer. An optional completer timeout is available.

## Interface

- `AW`, 5, address width.
- `DW`, 8, data width.
- `TIMEOUT_CYCLES`, 255, maximum ACCESS cycles before abort. Used only with the timeout feature.

Clock and reset:
- `PCLK`  in  1  clock.
- `PRESET`  in  1  reset. One clock; reset is synchronous and active-high.

Requester ports, n ∈ {0,1}:
- `Rn_PSEL`  in  1  transfer request.
- `Rn_PADDR`  in  AW  address.
- `Rn_PENABLE`  in  1  access phase.
- `Rn_PWRITE`  in  1  1 = write.
- `Rn_PWDATA`  in  DW  write data.
- `Rn_PRDATA`  out  DW  read data. Registered.
- `Rn_PREADY`  out  1  completion pulse.
- `Rn_PSLVERR`  out  1  timeout abort flag. Valid with PREADY.

Completer port:
- `C_PSEL`  out  1.
- `C_PADDR`  out  AW.
- `C_PENABLE`  out  1.
- `C_PWRITE`  out  1.
- `C_PWDATA`  out  DW.
- `C_PRDATA`  in  DW.
- `C_PREADY`  in  1.

Status:
- `GRANT`  out  2  one-hot owner of the current transfer. 0 when idle.

## Operation

FSM states are IDLE, SETUP, ACCESS and DONE.

IDLE:
- A request is any `Rn_PSEL=1`; the `PENABLE` value is ignored.
- No request: stay in IDLE.
- Exactly one request: grant it.
- Both requesting: grant the requester that is not `last`, where `last` is the most recently granted requester.
- On grant:
  - Capture `PADDR`, `PWRITE` and `PWDATA`.
  - Set `GRANT`.
  - Update `last`.
  - Go to SETUP.

SETUP:
- Drive `C_PSEL=1`, `C_PENABLE=0`, with the captured address and data.
- Go to ACCESS.

ACCESS:
- Drive `C_PSEL=1`, `C_PENABLE=1`.
- When `C_PREADY=1`:
  - Capture `C_PRDATA` into the owner's `Rn_PRDATA` (reads only; writes leave it unchanged).
  - Go to DONE.

DONE:
- Drive the owner's `Rn_PREADY=1` for exactly this cycle.
- `C_PSEL=0`, `C_PENABLE=0`.
- Clear `GRANT`.
- Go to IDLE.
- DONE exists so that the owner's `PSEL` for the finished transfer is never re-sampled as a new request.

Other rules:
- The non-owner's `PREADY` stays 0 throughout. Its request is held pending and is served next.
- Address and data are held on the completer from SETUP through ACCESS, even if the requester changes its inputs.
- `Rn_PRDATA` holds its value until the next read completes for that requester.
- A requester dropping `PSEL` after grant does not cancel the transfer. The transfer completes and PREADY pulses.

## Timing

- Reset values: all `C_*` outputs 0, `Rn_PREADY=0`, `Rn_PSLVERR=0`, `Rn_PRDATA=0`, `GRANT=0`, state IDLE, `last=R1` (so R0 wins the first tie).
- Reset mid-transfer: every output is at its reset value on the edge after `PRESET` is sampled high. The transfer is dropped and no PREADY is issued.
- Latency: request seen in IDLE at cycle t → SETUP at t+1 → ACCESS at t+2 → DONE/`Rn_PREADY` at t+2+w+1, where w is the number of completer wait cycles.
- Minimum is 4 cycles per transfer. Back-to-back transfers from alternating requesters also take 4 cycles each.
- Completer outputs are driven directly from registers, so there is no combinational path from requester inputs to completer outputs.

## Configuration

Macro: `APB_ARBITER_TIMEOUT_EN`.

Defined:
- A counter, width `$clog2(TIMEOUT_CYCLES+1)`, clears on entering ACCESS and increments each ACCESS cycle while `C_PREADY=0`.
- When the counter reaches `TIMEOUT_CYCLES` with `C_PREADY` still 0:
  - Abort to DONE.
  - Owner sees `PREADY=1` and `PSLVERR=1`.
  - On a read, `PRDATA` is loaded with all ones.
- A completer PREADY arriving on the same cycle as the limit wins: normal completion, `PSLVERR=0`.

Undefined:
- ACCESS waits indefinitely.
- `Rn_PSLVERR` is tied to 0 and no counter logic is present.

## Test plan

- R0 writes 0x5A to addr 3, completer `PREADY=1` immediately → `C_PSEL` rises at t+1, `C_PENABLE` at t+2, `R0_PREADY` pulses at t+3, `GRANT=01` during the transfer.
- R0 and R1 request in the same cycle out of reset (reads, addr 1 and 2) → R0 served first, then R1. `R1_PREADY` stays 0 until its own DONE. `R1_PRDATA` returns the completer value for addr 2.
- Completer inserts 3 wait states on an R1 read returning 0xC3 → `R1_PREADY` at t+6 with `R1_PRDATA=0xC3`. Completer address and data stable throughout.
- R0 requests continuously while R1 requests once → grants alternate R0, R1, R0. Neither requester is starved.
- `PRESET` asserted during ACCESS → all outputs 0 next cycle, no PREADY. The next request after reset is served normally.
- With `APB_ARBITER_TIMEOUT_EN`, `TIMEOUT_CYCLES=4`, completer never ready → owner sees `PREADY=1`, `PSLVERR=1`, `PRDATA=0xFF` after 4 ACCESS cycles. Without the macro, the arbiter stays in ACCESS.

Source files
------------

// File: rtl/apb_arbiter_if.sv
// APB-style bus bundle shared by the two requester ports and the completer
// port of apb_arbiter. The requester or arbiter side that starts transfers
// uses "master"; the side that answers them uses "slave".
interface apb_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 8
);
    logic          PSEL;
    logic [AW-1:0] PADDR;
    logic          PENABLE;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    modport master (
        output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_arbiter.sv
// apb_arbiter: shares one APB completer between two requesters with
// per-transfer round-robin arbitration. A granted transfer is captured,
// replayed on the completer as SETUP/ACCESS, and finished with a one-cycle
// DONE that returns PREADY (and read data) to the owner.
// Optional feature macro: APB_ARBITER_TIMEOUT_EN (abort ACCESS after
// TIMEOUT_CYCLES completer wait cycles with PSLVERR and all-ones read data).
module apb_arbiter #(
    parameter int AW             = 5,
    parameter int DW             = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          PCLK,
    input  logic          PRESET,
    apb_arbiter_if.slave  R0,
    apb_arbiter_if.slave  R1,
    apb_arbiter_if.master C,
    output logic [1:0]    GRANT
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic            r_last;
    logic [AW-1:0]   r_addr;
    logic            r_write;
    logic [DW-1:0]   r_wdata;
    logic            r_cPsel;
    logic            r_cPenable;
    logic [1:0]      r_grant;
    logic [1:0]      r_pready;
    logic [DW-1:0]   r_prdata0;
    logic [DW-1:0]   r_prdata1;

    logic            w_doGrant;
    logic            w_grantSel;
    logic            w_finish;
    logic            w_timeoutHit;
    logic [AW-1:0]   w_selAddr;
    logic            w_selWrite;
    logic [DW-1:0]   w_selWdata;
    logic [DW-1:0]   w_readData;
    logic            w_unusedPenable;

    // PENABLE from the requesters carries no meaning for arbitration
    assign w_unusedPenable = R0.PENABLE ^ R1.PENABLE;

    // Requester fields of whichever side wins this cycle
    assign w_selAddr  = w_grantSel ? R1.PADDR  : R0.PADDR;
    assign w_selWrite = w_grantSel ? R1.PWRITE : R0.PWRITE;
    assign w_selWdata = w_grantSel ? R1.PWDATA : R0.PWDATA;

    // A timeout abort reports all ones instead of completer data
    assign w_readData = C.PREADY ? C.PRDATA : '1;

    // Arbitration decision and next-state selection
    always_comb begin
        w_nextState = r_state;
        w_doGrant   = 1'b0;
        w_grantSel  = r_last;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (R0.PSEL && R1.PSEL) begin
                    w_doGrant  = 1'b1;
                    w_grantSel = ~r_last;
                end else if (R0.PSEL) begin
                    w_doGrant  = 1'b1;
                    w_grantSel = 1'b0;
                end else if (R1.PSEL) begin
                    w_doGrant  = 1'b1;
                    w_grantSel = 1'b1;
                end
                if (w_doGrant) begin
                    w_nextState = SETUP;
                end
            end
            SETUP:  w_nextState = ACCESS;
            ACCESS: begin
                if (C.PREADY || w_timeoutHit) begin
                    w_finish    = 1'b1;
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // State, captured transfer, registered completer drive and owner responses
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_cPsel    <= 1'b0;
            r_cPenable <= 1'b0;
            r_grant    <= 2'b00;
            r_pready   <= 2'b00;
            r_prdata0  <= '0;
            r_prdata1  <= '0;
        end else begin
            r_state    <= w_nextState;
            r_cPsel    <= (w_nextState == SETUP) || (w_nextState == ACCESS);
            r_cPenable <= (w_nextState == ACCESS);
            r_pready   <= 2'b00;
            if (w_doGrant) begin
                r_last  <= w_grantSel;
                r_addr  <= w_selAddr;
                r_write <= w_selWrite;
                r_wdata <= w_selWdata;
                r_grant <= w_grantSel ? 2'b10 : 2'b01;
            end
            if (w_finish) begin
                r_grant          <= 2'b00;
                r_pready[r_last] <= 1'b1;
                if (!r_write) begin
                    if (r_last) begin
                        r_prdata1 <= w_readData;
                    end else begin
                        r_prdata0 <= w_readData;
                    end
                end
            end
        end
    end

`ifdef APB_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_toCount;
    logic [1:0]    r_pslverr;

    // The count about to reach the limit with no PREADY aborts this cycle
    assign w_timeoutHit = (r_state == ACCESS) && !C.PREADY && (r_toCount == LIMIT);

    // ACCESS wait counter and the error flag that accompanies an abort
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_toCount <= '0;
            r_pslverr <= 2'b00;
        end else begin
            r_pslverr <= 2'b00;
            if (r_state == SETUP) begin
                r_toCount <= '0;
            end else if ((r_state == ACCESS) && !C.PREADY) begin
                r_toCount <= r_toCount + CW'(1);
            end
            if (w_timeoutHit) begin
                r_pslverr[r_last] <= 1'b1;
            end
        end
    end

    assign R0.PSLVERR = r_pslverr[0];
    assign R1.PSLVERR = r_pslverr[1];
`else
    localparam int unusedTimeoutCycles = TIMEOUT_CYCLES;

    assign w_timeoutHit = 1'b0;
    assign R0.PSLVERR   = 1'b0;
    assign R1.PSLVERR   = 1'b0;
`endif

    assign C.PSEL     = r_cPsel;
    assign C.PENABLE  = r_cPenable;
    assign C.PADDR    = r_addr;
    assign C.PWRITE   = r_write;
    assign C.PWDATA   = r_wdata;
    assign R0.PRDATA  = r_prdata0;
    assign R1.PRDATA  = r_prdata1;
    assign R0.PREADY  = r_pready[0];
    assign R1.PREADY  = r_pready[1];
    assign GRANT      = r_grant;
endmodule

// File: tb/tb_apb_arbiter.sv
// Testbench for apb_arbiter: random requesters and a random-wait completer
// memory, checked cycle by cycle against a transfer-level schedule model.
// With APB_ARBITER_TIMEOUT_EN the stalled transfer is expected to abort.
module tb_apb_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic [1:0]    grant;

    apb_arbiter_if #(.AW(AW), .DW(DW)) r0If ();
    apb_arbiter_if #(.AW(AW), .DW(DW)) r1If ();
    apb_arbiter_if #(.AW(AW), .DW(DW)) cIf ();

    apb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .R0     (r0If),
        .R1     (r1If),
        .C      (cIf),
        .GRANT  (grant)
    );

    // Free-running clock
    always #5 PCLK = ~PCLK;

    logic          reqPsel [2];
    logic          reqEn   [2];
    logic          reqWrite[2];
    logic [AW-1:0] reqAddr [2];
    logic [DW-1:0] reqWdata[2];
    logic          cReady;
    logic [DW-1:0] cRdata;

    assign r0If.PSEL    = reqPsel[0];
    assign r0If.PENABLE = reqEn[0];
    assign r0If.PWRITE  = reqWrite[0];
    assign r0If.PADDR   = reqAddr[0];
    assign r0If.PWDATA  = reqWdata[0];
    assign r1If.PSEL    = reqPsel[1];
    assign r1If.PENABLE = reqEn[1];
    assign r1If.PWRITE  = reqWrite[1];
    assign r1If.PADDR   = reqAddr[1];
    assign r1If.PWDATA  = reqWdata[1];
    assign cIf.PREADY   = cReady;
    assign cIf.PRDATA   = cRdata;
    assign cIf.PSLVERR  = 1'b0;

    int            vectorCount = 0;
    int            missCount   = 0;
    int            cyc         = 0;

    // Requester mode: 0 = no request, 1 = waiting for grant, 2 = owns a transfer
    int            reqMode[2];
    logic [AW-1:0] pAddr  [2];
    logic          pWrite [2];
    logic [DW-1:0] pWdata [2];

    // Transfer-level schedule: granted at tStart, w wait cycles, DONE at tStart+3+w
    bit            busy;
    int            tStart;
    int            wCnt;
    int            owner;
    int            mLast;
    bit            noReady;
    bit            abortHit;
    bit            stallNext;
    logic [AW-1:0] xAddr;
    logic          xWrite;
    logic [DW-1:0] xWdata;
    logic [DW-1:0] mem[32];
    logic [DW-1:0] mPrdata[2];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectorCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic resetModel();
        busy      = 1'b0;
        mLast     = 1;
        noReady   = 1'b0;
        abortHit  = 1'b0;
        stallNext = 1'b0;
        for (int n = 0; n < 2; n++) begin
            reqMode[n] = 0;
            mPrdata[n] = '0;
        end
    endtask

    task automatic driveIdle();
        for (int n = 0; n < 2; n++) begin
            reqPsel[n]  = 1'b0;
            reqEn[n]    = 1'b0;
            reqWrite[n] = 1'b0;
            reqAddr[n]  = '0;
            reqWdata[n] = '0;
        end
        cReady = 1'b0;
        cRdata = '0;
    endtask

    // Hold reset for one sampled edge, then expect every output at its reset value
    task automatic applyReset();
        @(negedge PCLK);
        PRESET = 1'b1;
        driveIdle();
        @(negedge PCLK);
        checkOutput("rst_grant",     grant,        0);
        checkOutput("rst_c_psel",    cIf.PSEL,     0);
        checkOutput("rst_c_penable", cIf.PENABLE,  0);
        checkOutput("rst_c_paddr",   cIf.PADDR,    0);
        checkOutput("rst_c_pwrite",  cIf.PWRITE,   0);
        checkOutput("rst_c_pwdata",  cIf.PWDATA,   0);
        checkOutput("rst_r0_pready", r0If.PREADY,  0);
        checkOutput("rst_r1_pready", r1If.PREADY,  0);
        checkOutput("rst_r0_pslverr", r0If.PSLVERR, 0);
        checkOutput("rst_r1_pslverr", r1If.PSLVERR, 0);
        checkOutput("rst_r0_prdata", r0If.PRDATA,  0);
        checkOutput("rst_r1_prdata", r1If.PRDATA,  0);
        PRESET = 1'b0;
        resetModel();
        cyc++;
    endtask

    // One cycle: check outputs against the schedule, then drive this cycle's inputs
    task automatic applyStimulus(input int reqPct);
        bit         wasBusy;
        bit         completing;
        int         rel;
        int         win;
        logic [1:0] expReady;
        logic [1:0] expErr;
        logic [1:0] expGrant;
        logic       expPsel;
        logic       expPen;

        wasBusy    = busy;
        completing = 1'b0;
        expReady   = 2'b00;
        expErr     = 2'b00;
        expGrant   = 2'b00;
        expPsel    = 1'b0;
        expPen     = 1'b0;
        if (busy) begin
            rel = cyc - tStart;
            if (rel == 1) begin
                expPsel  = 1'b1;
                expGrant = (owner == 1) ? 2'b10 : 2'b01;
            end else if (rel >= 2 && rel <= 2 + wCnt) begin
                expPsel  = 1'b1;
                expPen   = 1'b1;
                expGrant = (owner == 1) ? 2'b10 : 2'b01;
            end else if (rel == 3 + wCnt) begin
                completing      = 1'b1;
                expReady[owner] = 1'b1;
                expErr[owner]   = abortHit;
                if (!xWrite) begin
                    mPrdata[owner] = abortHit ? '1 : mem[xAddr];
                end else if (!abortHit) begin
                    mem[xAddr] = xWdata;
                end
            end
        end

        checkOutput("grant",      grant,        expGrant);
        checkOutput("c_psel",     cIf.PSEL,     expPsel);
        checkOutput("c_penable",  cIf.PENABLE,  expPen);
        if (expPsel) begin
            checkOutput("c_paddr",  cIf.PADDR,  xAddr);
            checkOutput("c_pwrite", cIf.PWRITE, xWrite);
            checkOutput("c_pwdata", cIf.PWDATA, xWdata);
        end
        checkOutput("r0_pready",  r0If.PREADY,  expReady[0]);
        checkOutput("r1_pready",  r1If.PREADY,  expReady[1]);
        checkOutput("r0_pslverr", r0If.PSLVERR, expErr[0]);
        checkOutput("r1_pslverr", r1If.PSLVERR, expErr[1]);
        checkOutput("r0_prdata",  r0If.PRDATA,  mPrdata[0]);
        checkOutput("r1_prdata",  r1If.PRDATA,  mPrdata[1]);

        if (completing) begin
            busy           = 1'b0;
            reqMode[owner] = 0;
        end

        for (int n = 0; n < 2; n++) begin
            if (reqMode[n] == 0 && $urandom_range(99) < reqPct) begin
                reqMode[n] = 1;
                pAddr[n]   = AW'($urandom);
                pWrite[n]  = 1'($urandom_range(1));
                pWdata[n]  = DW'($urandom);
            end
            if (reqMode[n] == 1) begin
                reqPsel[n]  = 1'b1;
                reqAddr[n]  = pAddr[n];
                reqWrite[n] = pWrite[n];
                reqWdata[n] = pWdata[n];
            end else begin
                reqPsel[n]  = (reqMode[n] == 2) ? 1'($urandom_range(1)) : 1'b0;
                reqAddr[n]  = AW'($urandom);
                reqWrite[n] = 1'($urandom_range(1));
                reqWdata[n] = DW'($urandom);
            end
            reqEn[n] = 1'($urandom_range(1));
        end

        if (!wasBusy && (reqMode[0] == 1 || reqMode[1] == 1)) begin
            if (reqMode[0] == 1 && reqMode[1] == 1) begin
                win = 1 - mLast;
            end else begin
                win = (reqMode[0] == 1) ? 0 : 1;
            end
            mLast        = win;
            owner        = win;
            busy         = 1'b1;
            tStart       = cyc;
            xAddr        = pAddr[win];
            xWrite       = pWrite[win];
            xWdata       = pWdata[win];
            reqMode[win] = 2;
            abortHit     = 1'b0;
            noReady      = 1'b0;
            if (stallNext) begin
                stallNext = 1'b0;
                noReady   = 1'b1;
`ifdef APB_ARBITER_TIMEOUT_EN
                wCnt      = TO - 1;
                abortHit  = 1'b1;
`else
                wCnt      = 100000;
`endif
            end else begin
                wCnt = $urandom_range(3);
            end
        end

        cReady = 1'($urandom_range(1));
        cRdata = DW'($urandom);
        if (busy) begin
            rel = cyc - tStart;
            if (rel >= 2 && rel <= 2 + wCnt) begin
                cReady = (rel == 2 + wCnt) && !noReady;
                if (cReady && !xWrite) begin
                    cRdata = mem[xAddr];
                end
            end
        end
        cyc++;
    endtask

    task automatic runCycles(input int count, input int reqPct);
        for (int i = 0; i < count; i++) begin
            @(negedge PCLK);
            applyStimulus(reqPct);
        end
    endtask

    // Test sequence
    initial begin
        bit found;
        driveIdle();
        for (int i = 0; i < 32; i++) begin
            mem[i] = DW'($urandom);
        end
        resetModel();
        applyReset();

        // Simultaneous reads out of reset: R0 wins the first tie
        reqMode[0] = 1; pAddr[0] = 5'd1; pWrite[0] = 1'b0; pWdata[0] = '0;
        reqMode[1] = 1; pAddr[1] = 5'd2; pWrite[1] = 1'b0; pWdata[1] = '0;
        runCycles(300, 30);
        runCycles(200, 90);

        // Reset while a transfer sits in ACCESS with wait states pending
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge PCLK);
            applyStimulus(60);
            if (busy && (cyc - tStart) >= 2 && (cyc - tStart) <= 1 + wCnt) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("midreset_window", found, 1);
        applyReset();
        runCycles(300, 50);

        // A completer that never answers
        stallNext = 1'b1;
        runCycles(40, 50);
`ifndef APB_ARBITER_TIMEOUT_EN
        applyReset();
`endif
        runCycles(100, 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
